program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream of the core's program memory. Receives a byte stream from a host link, UART receiver or debug port.
- Assembles little-endian 32-bit instruction words and writes them sequentially into program memory starting at word address 0.
- Holds `pgm` high for the whole load; the core treats `pgm` as program-mode and stays in reset.
- On a good load, drops `pgm` and pulses `done`; on a bad load, flags `error`.

Parameters:
- INSTR_ADDR_WIDTH, 10, word-address width of program memory; capacity = 2**INSTR_ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- pgm  output  1  program mode, high from accepted start until DONE/ERROR exit
- wr_en  output  1  single-cycle program memory write strobe
- wr_addr  output  INSTR_ADDR_WIDTH  word address for the write
- wr_data  output  32  instruction word for the write
- done  output  1  one-cycle pulse on successful load
- error  output  1  sticky fault flag, cleared by next accepted start or rst

Behaviour:
- Clocking and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - Reset values: byte_ready=0, pgm=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, state=IDLE, counters=0, checksum=0.
- Byte handshake: a byte transfers when byte_valid && byte_ready on a rising edge. byte_ready is high only in LEN_LO, LEN_HI, DATA and CHECK.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (first byte goes to word[7:0]), then one checksum byte equal to the XOR of all data bytes.
- FSM:
  - IDLE: start=1 -> LEN_LO; pgm<=1, error<=0, wr_addr<=0, checksum<=0, byte_idx<=0.
  - LEN_LO: on byte -> LEN_HI.
  - LEN_HI, on byte:
    - N==0 -> CHECK.
    - N > 2**INSTR_ADDR_WIDTH -> ERROR.
    - Otherwise -> DATA.
  - DATA, on byte: shift the byte into the word register at lane byte_idx, XOR it into checksum, byte_idx++. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. wr_en=1, wr_data = assembled word, byte_ready=0.
    - If this was word N-1 -> CHECK.
    - Otherwise wr_addr++ and -> DATA.
  - CHECK: on byte -> DONE if it equals checksum, else ERROR.
  - DONE: one cycle with done=1, pgm<=0 -> IDLE.
  - ERROR: one cycle, error<=1 (sticky), pgm<=0 -> IDLE.
- Latency: the write strobe is asserted in the cycle after the word's 4th byte is accepted. Maximum throughput is one byte per cycle, except the one-cycle WRITE bubble per word.
- wr_addr is held between writes and after completion. A full-capacity load ends with last address 2**INSTR_ADDR_WIDTH-1 and does not wrap.
- start is ignored outside IDLE, so start while busy has no effect. start and byte_valid in the same IDLE cycle: the byte is not consumed (byte_ready=0 in IDLE).
- byte_valid low mid-word: the FSM waits indefinitely, state and partial word held.
- rst mid-load: immediate return to IDLE with pgm=0. The partial word is discarded. Memory words already written are not restored. error is not set by reset.
- An ERROR exit leaves earlier written words in memory; the host must reload.
- wr_en is never high outside WRITE.

Decomposition:
- Shared package `loader_pkg` holds:
  - state encoding (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR, 3-bit);
  - header byte count (2);
  - bytes per word (4).
- Sub-module `byte_word_packer`: 8-bit in, 32-bit out, 2-bit lane index, clear input, word_full flag. It is reusable for a future data-memory loader.

Test Plan:
- Load N=1, bytes 01 00 13 05 A0 00 (word 0x00A00513), checksum 0xB6 -> one wr_en at addr 0 with data 0x00A00513, done pulse, pgm 1->0, error=0.
- Load N=3 of words 0x11111111, 0x22222222, 0x33333333, valid toggled every other cycle, checksum 0x00 -> writes at addr 0,1,2 with those values, no extra wr_en, done once.
- N=0 with checksum byte 0x00 -> no wr_en, done pulse. With checksum byte 0x01 instead -> error=1, no done.
- INSTR_ADDR_WIDTH=2, header N=5 -> error=1, pgm=0, no wr_en, subsequent data bytes see byte_ready=0.
- Corrupted checksum on N=2 -> both words written, error=1, done never pulses; next start clears error.
- rst asserted after 2 data bytes of word 1 -> next cycle pgm=0, state IDLE, no write of the partial word; a following full load starts again at addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM encoding and stream framing constants for memory loaders
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR} state_t;
    localparam int HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles little-endian bytes into a 32-bit word, flagging the completing byte
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);
    logic [1:0]  lane_q;
    logic [31:0] word_q, word_d;
    always_comb begin
        word_d = word_q;
        if (en_i) word_d[8*lane_q +: 8] = byte_i;
    end
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (en_i) begin
            lane_q <= lane_q + 2'd1;
            word_q <= word_d;
        end
    end
    assign word_o = word_q;
    assign full_o = en_i && lane_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/program_loader.sv
// program_loader: length-prefixed, XOR-checksummed byte stream to sequential program memory writes
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    output logic                        byte_ready,
    output logic                        pgm,
    output logic                        wr_en,
    output logic [INSTR_ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        done,
    output logic                        error
);
    state_t                      state_q;
    logic                        pgm_q, error_q, full;
    logic [INSTR_ADDR_WIDTH-1:0] wr_addr_q;
    logic [15:0]                 len_q, n_hdr;
    logic [7:0]                  csum_q;
    logic                        last_word;
    byte_word_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == IDLE && start),
        .en_i    (state_q == DATA && byte_valid),
        .byte_i  (byte_data),
        .word_o  (wr_data),
        .full_o  (full)
    );
    assign n_hdr     = {byte_data, len_q[7:0]};
    assign last_word = 32'(wr_addr_q) + 32'd1 == 32'(len_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pgm_q     <= 1'b0;
            error_q   <= 1'b0;
            wr_addr_q <= '0;
            len_q     <= '0;
            csum_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= LEN_LO;
                    pgm_q     <= 1'b1;
                    error_q   <= 1'b0;
                    wr_addr_q <= '0;
                    csum_q    <= '0;
                end
                LEN_LO: if (byte_valid) begin
                    len_q[7:0] <= byte_data;
                    state_q    <= LEN_HI;
                end
                LEN_HI: if (byte_valid) begin
                    len_q[15:8] <= byte_data;
                    state_q     <= n_hdr == 16'd0 ? CHECK :
                                   32'(n_hdr) > (32'd1 << INSTR_ADDR_WIDTH) ? ERROR : DATA;
                end
                DATA: if (byte_valid) begin
                    csum_q <= csum_q ^ byte_data;
                    if (full) state_q <= WRITE;
                end
                WRITE: begin
                    state_q <= last_word ? CHECK : DATA;
                    if (!last_word) wr_addr_q <= wr_addr_q + 1'b1;
                end
                CHECK: if (byte_valid) state_q <= byte_data == csum_q ? DONE : ERROR;
                DONE: begin
                    pgm_q   <= 1'b0;
                    state_q <= IDLE;
                end
                ERROR: begin
                    error_q <= 1'b1;
                    pgm_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign byte_ready = state_q == LEN_LO || state_q == LEN_HI || state_q == DATA || state_q == CHECK;
    assign wr_en      = state_q == WRITE;
    assign done       = state_q == DONE;
    assign pgm        = pgm_q;
    assign error      = error_q;
    assign wr_addr    = wr_addr_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader (full-size and 4-word instances)
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, pgm, wr_en, done, error;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        byte_ready2, pgm2, wr_en2, done2, error2;
    logic [1:0]  wr_addr2;
    logic [31:0] wr_data2;
    int          checks = 0, failures = 0, done_cnt = 0, wr2_cnt = 0;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader #(.INSTR_ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .pgm(pgm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .error(error)
    );
    program_loader #(.INSTR_ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready2), .pgm(pgm2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .done(done2), .error(error2)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            logic [41:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             wr_addr, wr_data, e[41:32], e[31:0]);
                end
            end
        end
        if (done) done_cnt++;
        if (wr_en2) wr2_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pgm_after_start", 32'(pgm), 32'd1);
        check("error_cleared_by_start", 32'(error), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!byte_ready) begin
            failures++;
            $display("FAIL byte_ready_timeout byte=%h", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input bit slow, input logic [7:0] csum_flip);
        logic [31:0] w[3];
        logic [7:0]  cs = 8'h00;
        logic [15:0] nn = 16'(n);
        w = '{w0, w1, w2};
        do_start();
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({10'(i), w[i]});
            for (int b = 0; b < 4; b++) begin
                if (slow) @(negedge clk);
                cs ^= w[i][8*b +: 8];
                send_byte(w[i][8*b +: 8]);
            end
        end
        send_byte(cs ^ csum_flip);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_pgm", 32'(pgm), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    task automatic test_single_word();
        int d0 = done_cnt;
        load(1, 32'h00A00513, 32'h0, 32'h0, 1'b0, 8'h00);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("single_pgm_low", 32'(pgm), 32'd0);
        check("single_error", 32'(error), 32'd0);
        check("single_pending", 32'(exp_q.size()), 32'd0);
        check("single_wr_addr_held", 32'(wr_addr), 32'd0);
    endtask

    task automatic test_three_slow();
        int d0 = done_cnt;
        load(3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 8'h00);
        check("three_done", 32'(done_cnt - d0), 32'd1);
        check("three_error", 32'(error), 32'd0);
        check("three_pending", 32'(exp_q.size()), 32'd0);
        check("three_last_addr", 32'(wr_addr), 32'd2);
    endtask

    task automatic test_zero_len();
        int d0 = done_cnt;
        load(0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00);
        check("zero_done", 32'(done_cnt - d0), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        d0 = done_cnt;
        load(0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h01);
        check("zero_bad_done", 32'(done_cnt - d0), 32'd0);
        check("zero_bad_error", 32'(error), 32'd1);
        check("zero_bad_pgm", 32'(pgm), 32'd0);
    endtask

    task automatic test_oversize();
        int w0;
        do_reset();
        w0 = wr2_cnt;
        do_start();
        send_byte(8'h05);
        send_byte(8'h00);
        @(negedge clk);
        check("over_error", 32'(error2), 32'd1);
        check("over_pgm", 32'(pgm2), 32'd0);
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            check("over_byte_ready", 32'(byte_ready2), 32'd0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("over_no_write", 32'(wr2_cnt - w0), 32'd0);
        do_reset();
    endtask

    task automatic test_bad_checksum();
        int d0 = done_cnt;
        load(2, 32'hCAFEF00D, 32'h12345678, 32'h0, 1'b0, 8'h5A);
        check("badcs_done", 32'(done_cnt - d0), 32'd0);
        check("badcs_error", 32'(error), 32'd1);
        check("badcs_pending", 32'(exp_q.size()), 32'd0);
        do_start();
        do_reset();
    endtask

    task automatic test_reset_mid_load();
        int d0;
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back({10'd0, 32'hA1B2C3D4});
        send_byte(8'hD4); send_byte(8'hC3); send_byte(8'hB2); send_byte(8'hA1);
        send_byte(8'h77); send_byte(8'h66);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_pgm", 32'(pgm), 32'd0);
        check("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        d0 = done_cnt;
        load(1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 8'h00);
        check("midrst_reload_done", 32'(done_cnt - d0), 32'd1);
        check("midrst_reload_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        test_reset();
        test_single_word();
        test_three_slow();
        test_zero_len();
        test_oversize();
        test_bad_checksum();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
